// File: rtl/regs_mover.sv
// Register-to-register move sequencer in front of the regs block (read on L, write back on W).
// Optional byte swap of the value in flight: define REGS_MOVER_SWAP_EN.
module regs_mover #(
    parameter int RD_CYC = 2,
    parameter int SETUP  = 1,
    parameter int WR_CYC = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  src,
    input  logic [2:0]  dst,
    input  logic        op_swap,
    output logic        busy,
    output logic        done,
    output logic [15:0] data,
    input  logic [15:0] l,
    output logic [15:0] w,
    output logic        ra,
    output logic        rb,
    output logic        czytrn_,
    output logic        czytrw_,
    output logic        piszrn_,
    output logic        piszrw_
);

    typedef enum logic [2:0] {IDLE, RD, SET, WR, FIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cntNext;
    logic [2:0]  r_src;
    logic [2:0]  r_dst;
    logic        r_swap;
    logic [15:0] r_data;
    logic [15:0] w_xfer;
    logic        w_rdLast;

`ifdef REGS_MOVER_SWAP_EN
    assign w_xfer = r_swap ? {r_data[7:0], r_data[15:8]} : r_data;
`else
    // Both arms identical: op_swap is latched but has no effect on the bus
    assign w_xfer = r_swap ? r_data : r_data;
`endif

    assign w_rdLast = (r_state == RD) && (r_cnt == 8'(RD_CYC - 1));
    assign data     = r_data;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_swap  <= 1'b0;
            r_data  <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cntNext;
            if (r_state == IDLE && start) begin
                r_src  <= src;
                r_dst  <= dst;
                r_swap <= op_swap;
            end
            if (w_rdLast) begin
                r_data <= l;
            end
        end
    end

    // Strobes and bus levels decode purely from state, so reset releases them immediately
    always_comb begin
        w_next    = r_state;
        w_cntNext = '0;
        busy      = 1'b0;
        done      = 1'b0;
        ra        = 1'b0;
        rb        = 1'b0;
        w         = 16'hffff;
        czytrn_   = 1'b1;
        czytrw_   = 1'b1;
        piszrn_   = 1'b1;
        piszrw_   = 1'b1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RD;
                end
            end
            RD: begin
                busy    = 1'b1;
                ra      = r_src[1];
                rb      = r_src[0];
                czytrn_ = r_src[2];
                czytrw_ = ~r_src[2];
                if (w_rdLast) begin
                    w_next = (SETUP == 0) ? WR : SET;
                end else begin
                    w_cntNext = r_cnt + 8'd1;
                end
            end
            SET: begin
                busy = 1'b1;
                ra   = r_dst[1];
                rb   = r_dst[0];
                w    = w_xfer;
                if (r_cnt == 8'(SETUP - 1)) begin
                    w_next = WR;
                end else begin
                    w_cntNext = r_cnt + 8'd1;
                end
            end
            WR: begin
                busy    = 1'b1;
                ra      = r_dst[1];
                rb      = r_dst[0];
                w       = w_xfer;
                piszrn_ = r_dst[2];
                piszrw_ = ~r_dst[2];
                if (r_cnt == 8'(WR_CYC - 1)) begin
                    w_next = FIN;
                end else begin
                    w_cntNext = r_cnt + 8'd1;
                end
            end
            FIN: begin
                done   = 1'b1;
                ra     = r_dst[1];
                rb     = r_dst[0];
                w      = w_xfer;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
